// File: rtl/lsu_axi_ctrl.sv
// Load/store unit: one outstanding access onto an AXI4-Lite data port, with store lane steering/strobes and load lane extraction/extension.
// States: IDLE wait request | RD_AR/RD_R read address/data | WR_REQ/WR_B write address+data/response | RESP one-cycle completion
module lsu_axi_ctrl #(
    parameter int XLEN   = 32,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic                 resp_misalign,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [ADDR_W-1:0]    araddr,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic [BUS_W-1:0]     rdata,
    input  logic [1:0]           rresp,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [ADDR_W-1:0]    awaddr,
    output logic                 wvalid,
    input  logic                 wready,
    output logic [BUS_W-1:0]     wdata,
    output logic [BUS_W/8-1:0]   wstrb,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic [1:0]           bresp
);

    localparam int STRB_W = BUS_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_AR,
        S_RD_R,
        S_WR_REQ,
        S_WR_B,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BUS_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                resp_misalign_q, resp_misalign_d;

    logic [OFF_W-1:0]    req_off;
    logic                req_misalign;
    logic [15:0]         strb_base;
    logic [STRB_W-1:0]   req_wstrb;
    logic [BUS_W-1:0]    req_wdata_bus;
    logic [BUS_W-1:0]    req_wdata_sh;

    assign req_off       = req_addr[OFF_W-1:0];
    assign req_wdata_bus = BUS_W'(req_wdata);
    assign req_wdata_sh  = req_wdata_bus << {req_off, 3'b000};
    assign req_wstrb     = STRB_W'(strb_base << req_off);

    always_comb begin
        req_misalign = 1'b0;
        strb_base    = 16'h0001;
        case (req_size)
            2'd0: begin
                req_misalign = 1'b0;
                strb_base    = 16'h0001;
            end
            2'd1: begin
                req_misalign = req_addr[0];
                strb_base    = 16'h0003;
            end
            2'd2: begin
                req_misalign = |req_addr[1:0];
                strb_base    = 16'h000F;
            end
            default: begin
                req_misalign = (XLEN == 32) || (|req_addr[2:0]);
                strb_base    = 16'h00FF;
            end
        endcase
    end

    // Load lane: shift the addressed bytes down, keep 1<<size bytes, then extend.
    logic [BUS_W-1:0]    rd_shift;
    logic [63:0]         rd_wide;
    logic [XLEN-1:0]     ld_raw;
    logic [XLEN-1:0]     ld_mask;
    logic                ld_sign;
    logic [XLEN-1:0]     ld_data;

    assign rd_shift = rdata >> {addr_q[OFF_W-1:0], 3'b000};
    assign rd_wide  = 64'(rd_shift);
    assign ld_raw   = rd_wide[XLEN-1:0];

    always_comb begin
        ld_mask = '1;
        ld_sign = 1'b0;
        case (size_q)
            2'd0: begin
                ld_mask = XLEN'(64'h0000_0000_0000_00FF);
                ld_sign = rd_wide[7];
            end
            2'd1: begin
                ld_mask = XLEN'(64'h0000_0000_0000_FFFF);
                ld_sign = rd_wide[15];
            end
            2'd2: begin
                ld_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
                ld_sign = rd_wide[31];
            end
            default: begin
                ld_mask = '1;
                ld_sign = 1'b0;
            end
        endcase
        ld_data = (ld_raw & ld_mask) | ((ld_sign && !uns_q) ? ~ld_mask : '0);
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        size_d          = size_q;
        uns_d           = uns_q;
        arvalid_d       = arvalid_q;
        rready_d        = rready_q;
        awvalid_d       = awvalid_q;
        wvalid_d        = wvalid_q;
        bready_d        = bready_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = '0;
        resp_err_d      = 1'b0;
        resp_misalign_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata_sh;
                    wstrb_d = req_wstrb;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (req_misalign) begin
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                        state_d         = S_RESP;
                    end else if (req_wen) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_AR;
                    end
                end
            end
            S_RD_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = rresp[1];
                    resp_rdata_d = rresp[1] ? '0 : ld_data;
                    state_d      = S_RESP;
                end
            end
            S_WR_REQ: begin
                // AW and W retire independently; move on once neither is pending.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!(awvalid_q && !awready) && !(wvalid_q && !wready)) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: begin
                if (bvalid) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = bresp[1];
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 1'b0;
            resp_misalign_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            arvalid_q       <= arvalid_d;
            rready_q        <= rready_d;
            awvalid_q       <= awvalid_d;
            wvalid_q        <= wvalid_d;
            bready_q        <= bready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            resp_misalign_q <= resp_misalign_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign resp_misalign = resp_misalign_q;
    assign arvalid       = arvalid_q;
    assign araddr        = addr_q;
    assign rready        = rready_q;
    assign awvalid       = awvalid_q;
    assign awaddr        = addr_q;
    assign wvalid        = wvalid_q;
    assign wdata         = wdata_q;
    assign wstrb         = wstrb_q;
    assign bready        = bready_q;

    logic unused_bits;
    assign unused_bits = ^{rresp[0], bresp[0], rd_wide};

endmodule
